// File: rtl/if_id_stage_ctrl.sv
// Fetch PC and IF/ID register driven by hazard stall/flush; one-cycle fetch latency, one bubble per redirect.
// Stall freezes PC and IF/ID and takes priority over flush; stall and flush counters saturate at all-ones.
module if_id_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flushIFID,
    input  logic             ID_is_jump,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      IF_ID_instr,
    output logic [31:0]      IF_ID_pc_plus4,
    output logic             IF_ID_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_plus4_q, pc_plus4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]      redirect_tgt;
    logic [31:0]      pc_inc;

    assign redirect_tgt = ID_is_jump ? jump_target : branch_target;
    assign pc_inc       = pc_q + 32'd4;

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // A redirect raised during a stall is dropped; the hazard unit reasserts it later.
        if (stall) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (flushIFID) begin
            pc_d       = {redirect_tgt[31:2], 2'b00};
            instr_d    = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else begin
            instr_d    = imem_rdata;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            pc_plus4_q  <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc             = pc_q;
    assign IF_ID_instr    = instr_q;
    assign IF_ID_pc_plus4 = pc_plus4_q;
    assign IF_ID_valid    = valid_q;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Randomized and directed bench for if_id_stage_ctrl against a cycle-level reference model.
module tb_if_id_stage_ctrl;

    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam int          CW      = 16;
    localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          flushIFID = 1'b0;
    logic          ID_is_jump = 1'b0;
    logic [31:0]   branch_target = 32'h0;
    logic [31:0]   jump_target = 32'h0;
    logic [31:0]   imem_rdata;
    logic [31:0]   pc;
    logic [31:0]   IF_ID_instr;
    logic [31:0]   IF_ID_pc_plus4;
    logic          IF_ID_valid;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;
    int          m_sc, m_fc;

    if_id_stage_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flushIFID(flushIFID),
        .ID_is_jump(ID_is_jump), .branch_target(branch_target),
        .jump_target(jump_target), .imem_rdata(imem_rdata), .pc(pc),
        .IF_ID_instr(IF_ID_instr), .IF_ID_pc_plus4(IF_ID_pc_plus4),
        .IF_ID_valid(IF_ID_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Instruction memory: each word is its address scrambled with a key.
    assign imem_rdata = pc ^ KEY;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("instr", IF_ID_instr, m_instr);
        chk("pc_plus4", IF_ID_pc_plus4, m_pp4);
        chk("valid", {31'h0, IF_ID_valid}, {31'h0, m_valid});
        chk("stall_cnt", {16'h0, stall_cnt}, m_sc[31:0]);
        chk("flush_cnt", {16'h0, flush_cnt}, m_fc[31:0]);
    endtask

    // One clock edge: advance the reference per the priority rules, then compare.
    task automatic step();
        logic [31:0] tgt;
        @(posedge clk);
        if (rst) begin
            m_pc = RST_PC; m_instr = 0; m_pp4 = 0; m_valid = 0; m_sc = 0; m_fc = 0;
        end else if (stall) begin
            m_sc = (m_sc == CNT_MAX) ? m_sc : m_sc + 1;
        end else if (flushIFID) begin
            tgt   = ID_is_jump ? jump_target : branch_target;
            m_pc  = tgt & 32'hFFFF_FFFC;
            m_instr = 0; m_pp4 = 0; m_valid = 0;
            m_fc  = (m_fc == CNT_MAX) ? m_fc : m_fc + 1;
        end else begin
            m_instr = m_pc ^ KEY;
            m_pp4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset
        rst = 1'b1; step(); step();
        rst = 1'b0;
        // Free run
        step(); step();
        chk("run_pc", pc, 32'h0040_0008);
        // Three-cycle stall at 0x0040_0008
        stall = 1'b1; step(); step(); step();
        chk("stall3_cnt", {16'h0, stall_cnt}, 32'd3);
        chk("stall3_pc", pc, 32'h0040_0008);
        stall = 1'b0; step();
        chk("resume_instr", IF_ID_instr, 32'h0040_0008 ^ KEY);
        step(); step();
        // Branch redirect with unaligned target
        flushIFID = 1'b1; ID_is_jump = 1'b0; branch_target = 32'h0040_0103; step();
        chk("br_pc", pc, 32'h0040_0100);
        chk("br_bubble", {31'h0, IF_ID_valid}, 32'd0);
        flushIFID = 1'b0; step();
        chk("br_instr", IF_ID_instr, 32'h0040_0100 ^ KEY);
        chk("br_fcnt", {16'h0, flush_cnt}, 32'd1);
        // Stall beats flush, then the reasserted flush takes effect
        stall = 1'b1; flushIFID = 1'b1; ID_is_jump = 1'b1; jump_target = 32'h0000_1000; step();
        chk("sf_fcnt", {16'h0, flush_cnt}, 32'd1);
        stall = 1'b0; step();
        chk("jmp_pc", pc, 32'h0000_1000);
        flushIFID = 1'b0; step();
        // PC wrap near the top of the address space
        flushIFID = 1'b1; ID_is_jump = 1'b0; branch_target = 32'hFFFF_FFF8; step();
        flushIFID = 1'b0; step();
        chk("wrap_pc1", pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc0", pc, 32'h0000_0000);
        chk("wrap_pp4", IF_ID_pc_plus4, 32'h0000_0000);
        step();
        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            flushIFID     = ($urandom_range(0, 5) == 0);
            ID_is_jump    = $urandom_range(0, 1) == 1;
            branch_target = $urandom;
            jump_target   = $urandom;
            rst           = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; stall = 1'b0; flushIFID = 1'b0;
        step();
        // Saturate the stall counter
        stall = 1'b1;
        for (int i = 0; i < CNT_MAX + 6; i++) step();
        chk("sat_cnt", {16'h0, stall_cnt}, 32'h0000_FFFF);
        // Reset mid-stall
        rst = 1'b1; flushIFID = 1'b1; step();
        chk("rst_pc", pc, RST_PC);
        chk("rst_scnt", {16'h0, stall_cnt}, 32'd0);
        rst = 1'b0; stall = 1'b0; flushIFID = 1'b0;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
